// File: rtl/keypad_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_lock_ctrl_if
// Brief    : Keypad input and lock status/display bundle for keypad_lock_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_lock_ctrl_if #(
    parameter int DIGITS    = 3,
    parameter int MAX_TRIES = 6
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    logic [15:0]         onehot;
    logic [4*DIGITS-1:0] display;
    logic [CW-1:0]       count;
    logic [TW-1:0]       tries;
    logic                unlocked;
    logic                locked_out;
    logic                buzzer;

    modport master (
        output onehot,
        input  display, count, tries, unlocked, locked_out, buzzer
    );

    modport slave (
        input  onehot,
        output display, count, tries, unlocked, locked_out, buzzer
    );
endinterface
`default_nettype wire

// File: rtl/keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_lock_ctrl
// Brief    : Keypad password lock with retry counting, buzzer bursts, lockout.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_lock_ctrl #(
    parameter int                    DIGITS      = 3,
    parameter logic [4*DIGITS-1:0]   PASSWORD    = 12'h246,
    parameter int                    MAX_TRIES   = 6,
    parameter int                    BEEP_HALF   = 50_000,
    parameter int                    BEEP_CYCLES = 150_000_000,
    parameter logic [3:0]            PASS_GLYPH  = 4'hA
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_lock_ctrl_if.slave    bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam int HW = $clog2(BEEP_HALF + 1);

    localparam logic [4*DIGITS-1:0] c_BLANK    = {DIGITS{4'hF}};
    localparam logic [4*DIGITS-1:0] c_ZEROS    = '0;
    localparam logic [4*DIGITS-1:0] c_GLYPHS   = {DIGITS{PASS_GLYPH}};
    localparam logic [CW-1:0]       c_FULL     = CW'(DIGITS);
    localparam logic [TW-1:0]       c_MAX      = TW'(MAX_TRIES);
    localparam logic [BW-1:0]       c_BEEP_END = BW'(BEEP_CYCLES - 1);
    localparam logic [BW-1:0]       c_BEEP_SAT = BW'(BEEP_CYCLES);
    localparam logic [HW-1:0]       c_HALF_END = HW'(BEEP_HALF - 1);

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_CHECK   = 3'd1,
        S_FAIL    = 3'd2,
        S_PASS    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t              state_q;
    logic [15:0]         onehot_q;
    logic [4*DIGITS-1:0] display_q;
    logic [CW-1:0]       count_q;
    logic [TW-1:0]       tries_q;
    logic                unlocked_q;
    logic                locked_out_q;
    logic                buzzer_q;
    logic [BW-1:0]       beep_cnt_q;
    logic [HW-1:0]       half_cnt_q;

    logic                w_key_evt;
    logic                w_is_digit;
    logic [3:0]          w_digit;
    logic                w_digit_evt;
    logic                w_enter_evt;
    logic                w_clear_evt;
    logic                w_admin_evt;
    logic [4*DIGITS+3:0] w_shift_cat;
    logic [TW-1:0]       w_tries_inc;

    // A press is a change to a new single-bit code; chords are never decoded.
    assign w_key_evt = (bus.onehot != onehot_q) && (bus.onehot != 16'd0) &&
                       ((bus.onehot & (bus.onehot - 16'd1)) == 16'd0);

    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = 4'd0;
        case (bus.onehot)
            16'h0008: w_digit = 4'd0;
            16'h0080: w_digit = 4'd1;
            16'h0040: w_digit = 4'd2;
            16'h0020: w_digit = 4'd3;
            16'h0800: w_digit = 4'd4;
            16'h0400: w_digit = 4'd5;
            16'h0200: w_digit = 4'd6;
            16'h8000: w_digit = 4'd7;
            16'h4000: w_digit = 4'd8;
            16'h2000: w_digit = 4'd9;
            default:  w_is_digit = 1'b0;
        endcase
    end

    assign w_digit_evt = w_key_evt && w_is_digit;
    assign w_enter_evt = w_key_evt && (bus.onehot == 16'h0001);
    assign w_clear_evt = w_key_evt && (bus.onehot == 16'h1000);
    assign w_admin_evt = w_key_evt && (bus.onehot == 16'h0100);
    assign w_shift_cat = {display_q, w_digit};
    assign w_tries_inc = tries_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ENTRY;
            onehot_q     <= 16'd0;
            display_q    <= c_BLANK;
            count_q      <= '0;
            tries_q      <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            buzzer_q     <= 1'b0;
            beep_cnt_q   <= '0;
            half_cnt_q   <= '0;
        end else begin
            onehot_q <= bus.onehot;
            if (w_admin_evt) begin
                state_q      <= S_ENTRY;
                display_q    <= c_BLANK;
                count_q      <= '0;
                tries_q      <= '0;
                unlocked_q   <= 1'b0;
                locked_out_q <= 1'b0;
                buzzer_q     <= 1'b0;
                beep_cnt_q   <= '0;
                half_cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_ENTRY: begin
                        if (w_digit_evt && (count_q < c_FULL)) begin
                            display_q <= w_shift_cat[4*DIGITS-1:0];
                            count_q   <= count_q + CW'(1);
                        end else if (w_clear_evt) begin
                            display_q <= c_BLANK;
                            count_q   <= '0;
                        end else if (w_enter_evt && (count_q == c_FULL)) begin
                            state_q <= S_CHECK;
                        end
                    end

                    S_CHECK: begin
                        if (display_q == PASSWORD) begin
                            state_q    <= S_PASS;
                            tries_q    <= '0;
                            display_q  <= c_GLYPHS;
                            unlocked_q <= 1'b1;
                        end else begin
                            if (tries_q < c_MAX) begin
                                tries_q <= w_tries_inc;
                            end
                            count_q    <= '0;
                            buzzer_q   <= 1'b1;
                            beep_cnt_q <= '0;
                            half_cnt_q <= '0;
                            if (w_tries_inc >= c_MAX) begin
                                state_q      <= S_LOCKOUT;
                                locked_out_q <= 1'b1;
                                display_q    <= c_ZEROS;
                            end else begin
                                state_q   <= S_FAIL;
                                display_q <= c_BLANK;
                            end
                        end
                    end

                    S_FAIL: begin
                        if (beep_cnt_q == c_BEEP_END) begin
                            buzzer_q   <= 1'b0;
                            beep_cnt_q <= c_BEEP_SAT;
                            half_cnt_q <= '0;
                            state_q    <= S_ENTRY;
                        end else begin
                            beep_cnt_q <= beep_cnt_q + BW'(1);
                            if (half_cnt_q == c_HALF_END) begin
                                half_cnt_q <= '0;
                                buzzer_q   <= ~buzzer_q;
                            end else begin
                                half_cnt_q <= half_cnt_q + HW'(1);
                            end
                        end
                    end

                    S_PASS: begin
                        if (w_clear_evt || w_enter_evt) begin
                            state_q    <= S_ENTRY;
                            display_q  <= c_BLANK;
                            count_q    <= '0;
                            unlocked_q <= 1'b0;
                        end
                    end

                    S_LOCKOUT: begin
                        // One burst only; the counter parks at saturation afterwards.
                        if (beep_cnt_q == c_BEEP_END) begin
                            buzzer_q   <= 1'b0;
                            beep_cnt_q <= c_BEEP_SAT;
                            half_cnt_q <= '0;
                        end else if (beep_cnt_q != c_BEEP_SAT) begin
                            beep_cnt_q <= beep_cnt_q + BW'(1);
                            if (half_cnt_q == c_HALF_END) begin
                                half_cnt_q <= '0;
                                buzzer_q   <= ~buzzer_q;
                            end else begin
                                half_cnt_q <= half_cnt_q + HW'(1);
                            end
                        end
                    end

                    default: begin
                        state_q <= S_ENTRY;
                    end
                endcase
            end
        end
    end

    assign bus.display    = display_q;
    assign bus.count      = count_q;
    assign bus.tries      = tries_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.locked_out = locked_out_q;
    assign bus.buzzer     = buzzer_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_lock_ctrl
// Brief    : Directed self-checking bench for keypad_lock_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_lock_ctrl;
    localparam int c_KEY_ENTER = 0;
    localparam int c_KEY_CLEAR = 12;
    localparam int c_KEY_ADMIN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   key_of_digit [10] = '{3, 7, 6, 5, 11, 10, 9, 15, 14, 13};

    keypad_lock_ctrl_if #(.DIGITS(3), .MAX_TRIES(3)) kif ();

    keypad_lock_ctrl #(
        .DIGITS      (3),
        .PASSWORD    (12'h246),
        .MAX_TRIES   (3),
        .BEEP_HALF   (2),
        .BEEP_CYCLES (20),
        .PASS_GLYPH  (4'hA)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int b);
        kif.onehot = 16'h0001 << b;
        tick(1);
        kif.onehot = 16'h0000;
        tick(1);
    endtask

    task automatic press_digit(input int d);
        press(key_of_digit[d]);
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2);
        press_digit(d0);
        press_digit(d1);
        press_digit(d2);
        press(c_KEY_ENTER);
    endtask

    initial begin
        kif.onehot = 16'h0000;
        rst = 1'b1;
        tick(3);
        check_eq("rst_display", 32'(kif.display), 32'hFFF);
        check_eq("rst_count", 32'(kif.count), 32'd0);
        check_eq("rst_tries", 32'(kif.tries), 32'd0);
        check_eq("rst_unlocked", 32'(kif.unlocked), 32'd0);
        check_eq("rst_locked", 32'(kif.locked_out), 32'd0);
        check_eq("rst_buzzer", 32'(kif.buzzer), 32'd0);
        rst = 1'b0;
        tick(1);

        // 1: correct code, two-cycle latency, then relock with CLEAR
        press_digit(2);
        press_digit(4);
        press_digit(6);
        check_eq("t1_display", 32'(kif.display), 32'h246);
        check_eq("t1_count", 32'(kif.count), 32'd3);
        kif.onehot = 16'h0001;
        tick(1);
        check_eq("t1_unlock_early", 32'(kif.unlocked), 32'd0);
        kif.onehot = 16'h0000;
        tick(1);
        check_eq("t1_unlocked", 32'(kif.unlocked), 32'd1);
        check_eq("t1_glyph", 32'(kif.display), 32'hAAA);
        check_eq("t1_tries", 32'(kif.tries), 32'd0);
        check_eq("t1_buzzer", 32'(kif.buzzer), 32'd0);
        press_digit(7);
        check_eq("t1_pass_digit", 32'(kif.display), 32'hAAA);
        press(c_KEY_CLEAR);
        check_eq("t1_relock", 32'(kif.unlocked), 32'd0);
        check_eq("t1_relock_disp", 32'(kif.display), 32'hFFF);

        // 2: wrong code, buzzer burst, digit during burst ignored
        enter_code(1, 2, 3);
        check_eq("t2_tries", 32'(kif.tries), 32'd1);
        check_eq("t2_display", 32'(kif.display), 32'hFFF);
        for (int k = 0; k < 20; k++) begin
            check_eq("t2_burst", 32'(kif.buzzer), ((k / 2) % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 4) kif.onehot = 16'h0008;
            if (k == 7) kif.onehot = 16'h0000;
            tick(1);
        end
        check_eq("t2_burst_end", 32'(kif.buzzer), 32'd0);
        check_eq("t2_count", 32'(kif.count), 32'd0);
        check_eq("t2_display_end", 32'(kif.display), 32'hFFF);
        tick(3);
        check_eq("t2_silent", 32'(kif.buzzer), 32'd0);

        // 3: held key counts once, repeat after release, overflow and short ENTER ignored
        kif.onehot = 16'h0800;
        tick(10);
        kif.onehot = 16'h0000;
        tick(1);
        check_eq("t3_held", 32'(kif.count), 32'd1);
        press_digit(4);
        check_eq("t3_count", 32'(kif.count), 32'd2);
        check_eq("t3_display", 32'(kif.display), 32'hF44);
        press(c_KEY_ENTER);
        tick(2);
        check_eq("t3_short_enter", 32'(kif.count), 32'd2);
        check_eq("t3_short_tries", 32'(kif.tries), 32'd1);
        check_eq("t3_short_buzz", 32'(kif.buzzer), 32'd0);
        press_digit(8);
        press_digit(9);
        check_eq("t3_overflow", 32'(kif.display), 32'h448);
        check_eq("t3_full", 32'(kif.count), 32'd3);
        press(c_KEY_CLEAR);
        check_eq("t3_clear", 32'(kif.display), 32'hFFF);
        check_eq("t3_clear_tries", 32'(kif.tries), 32'd1);

        // 4: reach lockout, correct code refused, ADMIN recovers
        press_digit(1);
        press_digit(1);
        press_digit(1);
        check_eq("t4_repeat", 32'(kif.display), 32'h111);
        press(c_KEY_ENTER);
        check_eq("t4_tries2", 32'(kif.tries), 32'd2);
        check_eq("t4_not_locked", 32'(kif.locked_out), 32'd0);
        tick(21);
        enter_code(9, 9, 9);
        check_eq("t4_tries3", 32'(kif.tries), 32'd3);
        check_eq("t4_locked", 32'(kif.locked_out), 32'd1);
        check_eq("t4_zeros", 32'(kif.display), 32'h000);
        check_eq("t4_buzz", 32'(kif.buzzer), 32'd1);
        tick(25);
        check_eq("t4_buzz_done", 32'(kif.buzzer), 32'd0);
        enter_code(2, 4, 6);
        tick(2);
        check_eq("t4_still_locked", 32'(kif.locked_out), 32'd1);
        check_eq("t4_no_unlock", 32'(kif.unlocked), 32'd0);
        check_eq("t4_disp_zero", 32'(kif.display), 32'h000);
        press(c_KEY_ADMIN);
        check_eq("t4_admin_lock", 32'(kif.locked_out), 32'd0);
        check_eq("t4_admin_tries", 32'(kif.tries), 32'd0);
        check_eq("t4_admin_disp", 32'(kif.display), 32'hFFF);

        // 5: chord ignored; reset in the middle of a burst
        kif.onehot = 16'h0088;
        tick(1);
        kif.onehot = 16'h0000;
        tick(1);
        check_eq("t5_chord", 32'(kif.count), 32'd0);
        enter_code(1, 2, 3);
        check_eq("t5_buzz_on", 32'(kif.buzzer), 32'd1);
        tick(3);
        rst = 1'b1;
        tick(1);
        check_eq("t5_rst_buzz", 32'(kif.buzzer), 32'd0);
        check_eq("t5_rst_tries", 32'(kif.tries), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
